spi_sensor_responder: RTL

Responder end of the SoC's three-wire sensor SPI link (cs_n, sck, so). Emulates a MAX6675-style thermocouple converter so the link can be tested end to end on-chip or in the SoC testbench.
- Runs periodic "conversions" that latch a 12-bit temperature code plus an open-thermocouple flag.
- Serves the latched result as a 16-bit frame, MSB first, SPI mode 0.
- Oversamples cs_n and sck on the system clock; it does not clock on sck.

---
 rtl/spi_sensor_responder_pkg.sv | 33 +++
 rtl/spi_in_sync.sv | 33 +++
 rtl/spi_sensor_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_sensor_responder_pkg.sv
// Shared constants, state encodings and frame packing for the MAX6675-style
// sensor SPI responder.
package spi_sensor_pkg;

    localparam int FRAME_BITS = 16;
    localparam int TEMP_MSB   = 14;
    localparam int TEMP_LSB   = 3;
    localparam int OPEN_BIT   = 2;
    localparam int ID_BIT     = 1;

    typedef enum logic {
        CONV,
        HOLD
    } conv_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } frame_state_t;

    // result = {temp[11:0], open}; the leading dummy bit, device id and
    // trailing three-state bit are all zero.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [12:0] result);
        logic [FRAME_BITS-1:0] frame;
        frame                    = '0;
        frame[TEMP_MSB:TEMP_LSB] = result[12:1];
        frame[OPEN_BIT]          = result[0];
        frame[ID_BIT]            = 1'b0;
        return frame;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for an asynchronous SPI pin, followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module spi_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the pin's idle level so releasing reset never looks like an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// Oversampled SPI responder emulating a MAX6675 thermocouple converter:
// periodic conversions latch a result that is served as a 16-bit mode-0 frame.
module spi_sensor_responder
    import spi_sensor_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CONV_CYCLES = 1000,
    parameter logic IDLE_SO     = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cs_n,
    input  logic        sck,
    output logic        so,
    output logic        so_oe,
    input  logic [11:0] temp_code,
    input  logic        tc_open,
    output logic        result_valid,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam int                CNT_W     = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [4:0]        LAST_BIT  = 5'(FRAME_BITS - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .resetn  (resetn),
        .pin_i   (cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk     (clk),
        .resetn  (resetn),
        .pin_i   (sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    conv_state_t           conv_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [12:0]           result_q;
    logic                  valid_q;

    frame_state_t          frame_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [4:0]            bit_cnt_q;
    logic                  so_q, so_oe_q, done_q, abort_q;

    logic [FRAME_BITS-1:0] frame_w;
    assign frame_w = make_frame(result_q);

    // NOTE: non-blocking assignments throughout sequential logic so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conv_q   <= CONV;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            unique case (conv_q)
                CONV: begin
                    // A selection wins over a completing conversion: the frame
                    // must carry the result that was stable before cs_n fell.
                    if (cs_fall) begin
                        conv_q <= HOLD;
                        cnt_q  <= '0;
                    end else if (cs_level) begin
                        if (cnt_q == CONV_LAST) begin
                            result_q <= {temp_code, tc_open};
                            valid_q  <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        conv_q <= CONV;
                        cnt_q  <= '0;
                    end
                end
                default: conv_q <= CONV;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            so_q      <= IDLE_SO;
            so_oe_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (frame_q)
                IDLE: begin
                    so_q    <= IDLE_SO;
                    so_oe_q <= 1'b0;
                    if (cs_fall) begin
                        shift_q   <= frame_w;
                        bit_cnt_q <= '0;
                        so_q      <= frame_w[FRAME_BITS-1];
                        so_oe_q   <= 1'b1;
                        frame_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect takes priority over a coincident sck fall.
                    if (cs_rise) begin
                        frame_q <= IDLE;
                        abort_q <= 1'b1;
                        so_q    <= IDLE_SO;
                        so_oe_q <= 1'b0;
                    end else if (sck_fall) begin
                        shift_q   <= shift_q << 1;
                        so_q      <= shift_q[FRAME_BITS-2];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            frame_q <= DONE;
                            so_q    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    so_q <= 1'b0;
                    if (cs_rise) begin
                        frame_q <= IDLE;
                        done_q  <= 1'b1;
                        so_q    <= IDLE_SO;
                        so_oe_q <= 1'b0;
                    end
                end
                default: frame_q <= IDLE;
            endcase
        end
    end

    assign so           = so_q;
    assign so_oe        = so_oe_q;
    assign result_valid = valid_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;

endmodule
